vga_timing_gen: RTL and testbench

//  Source end of the vga_intf stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk
//  for every pixel-clock tick. Its output feeds the draw chain (background, paddles, ball,

---
 rtl/vga_timing_gen_if.sv | 17 +
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel timing stream carried from the timing source down the draw chain.
//   hcount/vcount : current pixel position
//   hsync/vsync   : active-high sync pulses
//   hblnk/vblnk   : blanking flags (outside the visible area)
//   rgb           : pixel colour, painted by downstream stages
interface vga_timing_gen_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel/line counters with zero-skew sync and blank flags.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   en           : pixel advance enable; everything holds when low
//   tim_out      : timing stream (counts, syncs, blanks, rgb tied to 0)
//   frame_start  : one-clock pulse when the counts wrap to (0,0)
//   frame_cnt    : completed-frame counter, wraps
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter int unsigned FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    vga_timing_gen_if.out     tim_out,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]  hcount_q, hcount_d;
    logic [CNT_W-1:0]  vcount_q, vcount_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              hblnk_q, hblnk_d;
    logic              vblnk_q, vblnk_d;
    logic              frame_start_q, frame_start_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Next counts; flags decode the next counts so they register alongside them.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;

        if (en) begin
            // >= keeps any corrupted count from running past the wrap point
            if (hcount_q >= H_LAST) begin
                hcount_d = '0;
                if (vcount_q >= V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end

        hblnk_d = (hcount_d >= H_BLNK_BEG);
        hsync_d = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
        vblnk_d = (vcount_d >= V_BLNK_BEG);
        vsync_d = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign tim_out.hcount = hcount_q;
    assign tim_out.vcount = vcount_q;
    assign tim_out.hsync  = hsync_q;
    assign tim_out.vsync  = vsync_q;
    assign tim_out.hblnk  = hblnk_q;
    assign tim_out.vblnk  = vblnk_q;
    assign tim_out.rgb    = '0;
    assign frame_start    = frame_start_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: one DUT at default timing for line-level checks, one with a
// shrunken frame (16 x 11) so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    // small-frame geometry: H 8+2+3+3=16, V 6+1+2+2=11, 176 clocks/frame
    localparam int unsigned S_HA = 8;
    localparam int unsigned S_HF = 2;
    localparam int unsigned S_HS = 3;
    localparam int unsigned S_HB = 3;
    localparam int unsigned S_VA = 6;
    localparam int unsigned S_VF = 1;
    localparam int unsigned S_VS = 2;
    localparam int unsigned S_VB = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       b_fs, s_fs;
    logic [7:0] b_fc, s_fc;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if small_if ();

    vga_timing_gen u_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .tim_out     (big_if),
        .frame_start (b_fs),
        .frame_cnt   (b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .FCNT_W   (8)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .tim_out     (small_if),
        .frame_start (s_fs),
        .frame_cnt   (s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // expected state of each DUT
    int unsigned bh, bv, bfc;
    int unsigned sh, sv, sfc;
    bit          bfs, sfs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int unsigned ht, input int unsigned vt, input bit e,
                              inout int unsigned h, inout int unsigned v,
                              inout int unsigned fc, inout bit fs);
        fs = 1'b0;
        if (e) begin
            if (h == ht - 1) begin
                h = 0;
                if (v == vt - 1) begin
                    v  = 0;
                    fs = 1'b1;
                    fc = (fc + 1) % 256;
                end else begin
                    v = v + 1;
                end
            end else begin
                h = h + 1;
            end
        end
    endtask

    task automatic model_reset();
        bh = 0; bv = 0; bfc = 0; bfs = 1'b0;
        sh = 0; sv = 0; sfc = 0; sfs = 1'b0;
    endtask

    task automatic check_all();
        chk("big_hcount", 32'(big_if.hcount), bh);
        chk("big_vcount", 32'(big_if.vcount), bv);
        chk("big_hblnk",  32'(big_if.hblnk), 32'(bh >= 800));
        chk("big_hsync",  32'(big_if.hsync), 32'(bh >= 840 && bh < 968));
        chk("big_vblnk",  32'(big_if.vblnk), 32'(bv >= 600));
        chk("big_vsync",  32'(big_if.vsync), 32'(bv >= 601 && bv < 605));
        chk("big_rgb",    32'(big_if.rgb), 0);
        chk("big_fstart", 32'(b_fs), 32'(bfs));
        chk("big_fcnt",   32'(b_fc), bfc);
        chk("sm_hcount",  32'(small_if.hcount), sh);
        chk("sm_vcount",  32'(small_if.vcount), sv);
        chk("sm_hblnk",   32'(small_if.hblnk), 32'(sh >= 8));
        chk("sm_hsync",   32'(small_if.hsync), 32'(sh >= 10 && sh < 13));
        chk("sm_vblnk",   32'(small_if.vblnk), 32'(sv >= 6));
        chk("sm_vsync",   32'(small_if.vsync), 32'(sv >= 7 && sv < 9));
        chk("sm_rgb",     32'(small_if.rgb), 0);
        chk("sm_fstart",  32'(s_fs), 32'(sfs));
        chk("sm_fcnt",    32'(s_fc), sfc);
    endtask

    // one clock: update expectations at the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(1056, 628, en, bh, bv, bfc, bfs);
            model_step(16, 11, en, sh, sv, sfc, sfs);
        end
        @(negedge clk);
        check_all();
    endtask

    int hs_cnt;
    int vs_cnt;
    int vb_cnt;
    int fs_cnt;
    int guard;
    int period;
    bit found;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();

        // reset held with en=1
        repeat (10) tick();
        chk("rst_hcount", 32'(big_if.hcount), 0);
        chk("rst_fcnt",   32'(b_fc), 0);

        // release: counts start at 1
        rst_n = 1'b1;
        tick();
        chk("rel_h1", 32'(big_if.hcount), 1);
        chk("rel_v0", 32'(big_if.vcount), 0);
        chk("rel_fs", 32'(b_fs), 0);
        tick();
        chk("rel_h2", 32'(big_if.hcount), 2);
        tick();
        chk("rel_h3", 32'(big_if.hcount), 3);
        chk("rel_sm_h3", 32'(small_if.hcount), 3);

        // line 0 of the default DUT: blank/sync edges and sync width
        hs_cnt = 0;
        for (int i = 0; i < 1052; i++) begin
            tick();
            if (big_if.hsync === 1'b1) hs_cnt++;
            if (bh == 799) chk("hblnk_799", 32'(big_if.hblnk), 0);
            if (bh == 800) chk("hblnk_800", 32'(big_if.hblnk), 1);
            if (bh == 839) chk("hsync_839", 32'(big_if.hsync), 0);
            if (bh == 840) chk("hsync_840", 32'(big_if.hsync), 1);
            if (bh == 967) chk("hsync_967", 32'(big_if.hsync), 1);
            if (bh == 968) chk("hsync_968", 32'(big_if.hsync), 0);
        end
        chk("line_end_h", 32'(big_if.hcount), 1055);
        chk("hsync_width", 32'(hs_cnt), 128);
        tick();
        chk("line_wrap_h", 32'(big_if.hcount), 0);
        chk("line_wrap_v", 32'(big_if.vcount), 1);
        chk("line_wrap_hblnk", 32'(big_if.hblnk), 0);
        // 1056 clocks = exactly 6 small frames
        chk("sm_six_frames", 32'(s_fc), 6);
        chk("sm_fs_at_00", 32'(s_fs), 1);
        chk("sm_pos_00", 32'({small_if.hcount, small_if.vcount}), 0);

        // one full small frame: sync/blank extents and a single frame_start
        vs_cnt = 0; vb_cnt = 0; fs_cnt = 0;
        repeat (176) begin
            tick();
            if (small_if.vsync === 1'b1) vs_cnt++;
            if (small_if.vblnk === 1'b1) vb_cnt++;
            if (s_fs === 1'b1) fs_cnt++;
        end
        chk("sm_vsync_cycles", 32'(vs_cnt), 32);
        chk("sm_vblnk_cycles", 32'(vb_cnt), 80);
        chk("sm_fs_pulses", 32'(fs_cnt), 1);
        chk("sm_fcnt_7", 32'(s_fc), 7);

        // enable toggled every clock: frame period doubles to 352
        found = 1'b0;
        guard = 0;
        while (!found && guard < 1000) begin
            en = ~en;
            tick();
            guard++;
            if (s_fs === 1'b1) found = 1'b1;
        end
        chk("toggle_first_fs", 32'(found), 1);
        found  = 1'b0;
        period = 0;
        while (!found && period < 1000) begin
            en = ~en;
            tick();
            period++;
            if (s_fs === 1'b1) found = 1'b1;
        end
        chk("toggle_period", 32'(period), 352);
        en = 1'b1;

        // frame_cnt wrap 255 -> 0
        guard = 0;
        while (s_fc !== 8'd255 && guard < 50000) begin
            tick();
            guard++;
        end
        chk("fcnt_reach_255", 32'(s_fc), 255);
        guard = 0;
        do begin
            tick();
            guard++;
        end while (s_fs !== 1'b1 && guard < 400);
        chk("fcnt_wrap_fs", 32'(s_fs), 1);
        chk("fcnt_wrap_0", 32'(s_fc), 0);

        // async reset between edges at big hcount 500
        guard = 0;
        while (bh != 500 && guard < 1200) begin
            tick();
            guard++;
        end
        chk("pre_arst_h500", 32'(big_if.hcount), 500);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_h0", 32'(big_if.hcount), 0);
        chk("arst_v0", 32'(big_if.vcount), 0);
        chk("arst_fcnt0", 32'(s_fc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_rel_h1", 32'(big_if.hcount), 1);
        chk("arst_rel_v0", 32'(big_if.vcount), 0);
        chk("arst_rel_sm_h1", 32'(small_if.hcount), 1);
        tick();
        chk("arst_rel_h2", 32'(big_if.hcount), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
